// File: rtl/vc_dest_router.sv
// rtl/vc_dest_router.sv - routes popped VC0/VC1 words to delay FIFO D0/D1 by destination bit
module vc_dest_router #(
  parameter int DATA_W   = 6,
  parameter int DEST_BIT = 4,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              pop_vc0,
  input  logic              pop_vc1,
  input  logic [DATA_W-1:0] data_vc0,
  input  logic [DATA_W-1:0] data_vc1,
  input  logic              fifo_full_d0,
  input  logic              fifo_full_d1,
  output logic              push_d0,
  output logic              push_d1,
  output logic [DATA_W-1:0] data_d0,
  output logic [DATA_W-1:0] data_d1,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              idle,
  output logic              overflow_err,
  output logic              conflict_err
);

  logic              sel_a;
  logic              val_a;
  logic              val_b0;
  logic              val_b1;
  logic [DATA_W-1:0] word_a;
  logic              dest_a;

  always_comb begin
    word_a = sel_a ? data_vc1 : data_vc0;
    dest_a = word_a[DEST_BIT];
  end

  // Stage B splits by destination straight into the per-FIFO data registers,
  // so data_dX naturally holds its last pushed value between pushes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_a        <= 1'b0;
      val_a        <= 1'b0;
      val_b0       <= 1'b0;
      val_b1       <= 1'b0;
      data_d0      <= '0;
      data_d1      <= '0;
      cnt_d0       <= '0;
      cnt_d1       <= '0;
      overflow_err <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      sel_a  <= pop_vc1 & ~pop_vc0;
      val_a  <= pop_vc0 | pop_vc1;
      val_b0 <= val_a & ~dest_a;
      val_b1 <= val_a & dest_a;
      if (val_a && !dest_a) data_d0 <= word_a;
      if (val_a && dest_a)  data_d1 <= word_a;
      if (push_d0) cnt_d0 <= cnt_d0 + CNT_W'(1);
      if (push_d1) cnt_d1 <= cnt_d1 + CNT_W'(1);
      if ((push_d0 && fifo_full_d0) || (push_d1 && fifo_full_d1)) overflow_err <= 1'b1;
      if (pop_vc0 && pop_vc1) conflict_err <= 1'b1;
    end
  end

  assign push_d0 = val_b0;
  assign push_d1 = val_b1;
  assign idle    = ~val_a & ~val_b0 & ~val_b1 & ~pop_vc0 & ~pop_vc1;

endmodule
